// File: rtl/fsm_pkg.sv
// Shared definitions for the run detector and its bit_serializer source stage.
package fsm_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  localparam logic IDLE_LEVEL_DEF = 1'b0;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial source: accepts words over valid/ready and shifts them out
// MSB-first, each bit held REPEAT cycles, with a one-word buffer for gapless streaming.
module bit_serializer
  import fsm_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter int   REPEAT     = 1,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             word_done
);

  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;

  ser_state_e       state_r, state_nxt_s;
  logic [WIDTH-1:0] shreg_r, shreg_nxt_s;
  logic [WIDTH-1:0] buf_r, buf_nxt_s;
  logic             buf_full_r, buf_full_nxt_s;
  logic [BW-1:0]    bit_cnt_r, bit_cnt_nxt_s;
  logic [RW-1:0]    rep_cnt_r, rep_cnt_nxt_s;
  logic             accept_s, last_rep_s, final_s;
  logic             x_nxt_s, x_valid_nxt_s, word_done_nxt_s;

  assign accept_s   = din_valid && din_ready;
  assign last_rep_s = (rep_cnt_r == RW'(REPEAT - 1));
  assign final_s    = (state_r == SHIFT) && (bit_cnt_r == {BW{1'b0}}) && last_rep_s;

  // Next-state: FSM, counters, shifter and holding buffer.
  always_comb begin
    state_nxt_s    = state_r;
    shreg_nxt_s    = shreg_r;
    buf_nxt_s      = buf_r;
    buf_full_nxt_s = buf_full_r;
    bit_cnt_nxt_s  = bit_cnt_r;
    rep_cnt_nxt_s  = rep_cnt_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s   = SHIFT;
          shreg_nxt_s   = din;
          bit_cnt_nxt_s = BW'(WIDTH - 1);
          rep_cnt_nxt_s = {RW{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (final_s) begin
          bit_cnt_nxt_s = BW'(WIDTH - 1);
          rep_cnt_nxt_s = {RW{1'b0}};
          // Buffered word has priority; a same-edge accept refills the buffer.
          if (buf_full_r) begin
            shreg_nxt_s = buf_r;
            if (accept_s) begin
              buf_nxt_s      = din;
              buf_full_nxt_s = 1'b1;
            end else begin
              buf_full_nxt_s = 1'b0;
            end
          end else if (accept_s) begin
            shreg_nxt_s = din;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          if (last_rep_s) begin
            rep_cnt_nxt_s = {RW{1'b0}};
            shreg_nxt_s   = {shreg_r[WIDTH-2:0], 1'b0};
            bit_cnt_nxt_s = bit_cnt_r - BW'(1);
          end else begin
            rep_cnt_nxt_s = rep_cnt_r + RW'(1);
          end
          if (accept_s) begin
            buf_nxt_s      = din;
            buf_full_nxt_s = 1'b1;
          end else begin
            buf_full_nxt_s = buf_full_r;
          end
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output values for the next cycle, derived from next state so outputs stay registered.
  always_comb begin
    x_nxt_s         = IDLE_LEVEL;
    x_valid_nxt_s   = 1'b0;
    word_done_nxt_s = 1'b0;
    if (state_nxt_s == SHIFT) begin
      x_nxt_s         = shreg_nxt_s[WIDTH-1];
      x_valid_nxt_s   = 1'b1;
      word_done_nxt_s = (bit_cnt_nxt_s == {BW{1'b0}}) && (rep_cnt_nxt_s == RW'(REPEAT - 1));
    end else begin
      x_nxt_s = IDLE_LEVEL;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= IDLE;
      shreg_r    <= {WIDTH{1'b0}};
      buf_r      <= {WIDTH{1'b0}};
      buf_full_r <= 1'b0;
      bit_cnt_r  <= {BW{1'b0}};
      rep_cnt_r  <= {RW{1'b0}};
      din_ready  <= 1'b1;
      x          <= IDLE_LEVEL;
      x_valid    <= 1'b0;
      word_done  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      shreg_r    <= shreg_nxt_s;
      buf_r      <= buf_nxt_s;
      buf_full_r <= buf_full_nxt_s;
      bit_cnt_r  <= bit_cnt_nxt_s;
      rep_cnt_r  <= rep_cnt_nxt_s;
      din_ready  <= !buf_full_nxt_s;
      x          <= x_nxt_s;
      x_valid    <= x_valid_nxt_s;
      word_done  <= word_done_nxt_s;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: instance 0 has REPEAT=1, instance 1 has REPEAT=3.
module tb_bit_serializer;

  typedef struct packed {
    logic b;
    logic wd;
  } exp_t;

  logic       clock;
  logic       rst_s    [2];
  logic [7:0] din_s    [2];
  logic       dv_s     [2];
  logic       rdy_s    [2];
  logic       x_s      [2];
  logic       xv_s     [2];
  logic       wd_s     [2];

  exp_t q [2][$];
  int   run_len  [2];
  int   last_run [2];
  int   wd_cnt   [2];
  int   det_run;
  int   det_hits;
  logic mon_en;
  int   tests;
  int   fails;

  bit_serializer #(.WIDTH(8), .REPEAT(1), .IDLE_LEVEL(1'b0)) u_dut_r1 (
    .clock(clock), .reset(rst_s[0]), .din(din_s[0]), .din_valid(dv_s[0]),
    .din_ready(rdy_s[0]), .x(x_s[0]), .x_valid(xv_s[0]), .word_done(wd_s[0])
  );

  bit_serializer #(.WIDTH(8), .REPEAT(3), .IDLE_LEVEL(1'b0)) u_dut_r3 (
    .clock(clock), .reset(rst_s[1]), .din(din_s[1]), .din_valid(dv_s[1]),
    .din_ready(rdy_s[1]), .x(x_s[1]), .x_valid(xv_s[1]), .word_done(wd_s[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every valid bit, checks idle level otherwise.
  always @(negedge clock) begin
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        if (xv_s[i] === 1'b1) begin
          exp_t e;
          run_len[i]++;
          if (wd_s[i]) wd_cnt[i]++;
          if (q[i].size() == 0) begin
            chk($sformatf("unexpected_bit[%0d]", i), 32'd1, 32'd0);
          end else begin
            e = q[i].pop_front();
            chk($sformatf("bit[%0d]", i), {30'd0, x_s[i], wd_s[i]}, {30'd0, e.b, e.wd});
          end
          if (i == 0) begin
            det_run = x_s[0] ? det_run + 1 : 0;
            if (det_run == 4) det_hits++;
          end
        end else begin
          if (run_len[i] != 0) last_run[i] = run_len[i];
          run_len[i] = 0;
          if (i == 0) det_run = 0;
          chk($sformatf("idle[%0d]", i), {30'd0, x_s[i], wd_s[i]}, 32'd0);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  // Presents a word and pushes its expected bit stream once the DUT will accept it.
  task automatic send(input int i, input logic [7:0] w, input int rep);
    int t;
    t = 0;
    din_s[i] = w;
    dv_s[i]  = 1'b1;
    while (rdy_s[i] !== 1'b1 && t < 300) begin
      tick();
      t++;
    end
    if (rdy_s[i] !== 1'b1) begin
      chk($sformatf("ready_timeout[%0d]", i), 32'd0, 32'd1);
    end else begin
      for (int b = 7; b >= 0; b--)
        for (int r = 0; r < rep; r++)
          q[i].push_back('{b: w[b], wd: (b == 0 && r == rep - 1)});
    end
    tick();
  endtask

  task automatic drain(input int i);
    int t;
    t = 0;
    while (q[i].size() != 0 && t < 500) begin
      tick();
      t++;
    end
    chk($sformatf("drain_timeout[%0d]", i), q[i].size(), 32'd0);
    tick();
    tick();
  endtask

  initial begin
    int wd0;
    int hits0;
    tests = 0; fails = 0; mon_en = 1'b0;
    det_run = 0; det_hits = 0;
    for (int i = 0; i < 2; i++) begin
      rst_s[i] = 1'b1; dv_s[i] = 1'b0; din_s[i] = 8'h00;
      run_len[i] = 0; last_run[i] = 0; wd_cnt[i] = 0;
    end
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_ready[%0d]", i), {31'd0, rdy_s[i]}, 32'd1);
      chk($sformatf("rst_outs[%0d]", i), {29'd0, x_s[i], xv_s[i], wd_s[i]}, 32'd0);
    end
    // A transfer attempted during reset is discarded.
    din_s[0] = 8'hFF; dv_s[0] = 1'b1;
    tick();
    dv_s[0] = 1'b0;
    rst_s[0] = 1'b0; rst_s[1] = 1'b0;
    mon_en = 1'b1;
    tick(); tick();
    chk("rst_discard_xv", {31'd0, xv_s[0]}, 32'd0);

    // F0 with REPEAT=1, feeding the run-detector model.
    wd0 = wd_cnt[0]; hits0 = det_hits;
    send(0, 8'hF0, 1);
    dv_s[0] = 1'b0;
    chk("f0_first_bit_valid", {31'd0, xv_s[0]}, 32'd1);
    drain(0);
    chk("f0_len", last_run[0], 32'd8);
    chk("f0_word_done", wd_cnt[0] - wd0, 32'd1);
    chk("f0_detector_hit", det_hits - hits0, 32'd1);

    // 81 with REPEAT=3: 24 cycles, one word_done.
    send(1, 8'h81, 3);
    dv_s[1] = 1'b0;
    drain(1);
    chk("r3_81_len", last_run[1], 32'd24);
    chk("r3_81_word_done", wd_cnt[1], 32'd1);

    // AA,55,FF streamed with valid held high.
    wd0 = wd_cnt[0];
    send(0, 8'hAA, 1);
    send(0, 8'h55, 1);
    chk("stream_ready_low", {31'd0, rdy_s[0]}, 32'd0);
    send(0, 8'hFF, 1);
    dv_s[0] = 1'b0;
    drain(0);
    chk("stream_len", last_run[0], 32'd24);
    chk("stream_word_done", wd_cnt[0] - wd0, 32'd3);

    // 0F presented through the final bit-cycle with a full buffer (REPEAT=3).
    send(1, 8'h11, 3);
    send(1, 8'h22, 3);
    send(1, 8'h0F, 3);
    dv_s[1] = 1'b0;
    drain(1);
    chk("full_buf_len", last_run[1], 32'd72);
    chk("full_buf_word_done", wd_cnt[1], 32'd4);

    // Reset in cycle 4 of C3 with 3C buffered.
    wd0 = wd_cnt[0];
    send(0, 8'hC3, 1);
    send(0, 8'h3C, 1);
    dv_s[0] = 1'b0;
    tick(); tick();
    rst_s[0] = 1'b1;
    q[0].delete();
    tick();
    chk("midrst_outs", {30'd0, x_s[0], xv_s[0]}, 32'd0);
    chk("midrst_ready", {31'd0, rdy_s[0]}, 32'd1);
    rst_s[0] = 1'b0;
    for (int t = 0; t < 30; t++) tick();
    chk("midrst_no_word_done", wd_cnt[0] - wd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
